// File: rtl/row_feed_if.sv
// row_feed_if: write/pop handshake, per-row status and output bus of row_feed_buf.
interface row_feed_if #(
  parameter int WORDLEN = 8,
  parameter int ROWS = 16
);
  localparam int RB = ROWS > 1 ? $clog2(ROWS) : 1;
  logic flush, wr_valid, wr_ready, rd_en, rd_ready, busy;
  logic [RB-1:0] wr_row;
  logic [WORDLEN-1:0] wr_data;
  logic [ROWS*WORDLEN-1:0] out_data;
  logic [ROWS-1:0] out_valid, empty, full;
  modport master (
    output flush, wr_valid, wr_row, wr_data, rd_en,
    input wr_ready, rd_ready, out_data, out_valid, empty, full, busy
  );
  modport slave (
    input flush, wr_valid, wr_row, wr_data, rd_en,
    output wr_ready, rd_ready, out_data, out_valid, empty, full, busy
  );
endinterface

// File: rtl/row_feed_buf.sv
// row_feed_buf: per-row circular FIFOs popped in lockstep, feeding a row skew pipeline.
// Define ROW_FEED_SKEW_EN to delay row r by 1+r cycles; otherwise all rows emerge together.
module row_feed_buf #(
  parameter int WORDLEN = 8,
  parameter int DEPTH = 8,
  parameter int ROWS = 16
) (
  input logic clk,
  input logic rst,
  row_feed_if.slave bus
);
  localparam int RB = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [ROWS-1:0] sel, we;
  logic [ROWS*WORDLEN-1:0] head;
  logic pop;
  assign bus.rd_ready = ~|bus.empty;
  assign bus.wr_ready = |(sel & ~bus.full);
  assign we = (bus.wr_valid && !bus.flush) ? (sel & ~bus.full) : '0;
  assign pop = bus.rd_en && bus.rd_ready && !bus.flush;
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [WORDLEN-1:0] mem_q [DEPTH];
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    assign sel[r] = bus.wr_row == RB'(r);
    assign bus.empty[r] = cnt_q == '0;
    assign bus.full[r] = cnt_q == CW'(DEPTH);
    assign head[r*WORDLEN +: WORDLEN] = mem_q[rptr_q];
    always_comb begin
      rptr_d = pop ? (rptr_q == PW'(DEPTH - 1) ? '0 : rptr_q + PW'(1)) : rptr_q;
      wptr_d = we[r] ? (wptr_q == PW'(DEPTH - 1) ? '0 : wptr_q + PW'(1)) : wptr_q;
      cnt_d = cnt_q + CW'(we[r]) - CW'(pop);
    end
    always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
        rptr_q <= '0;
        wptr_q <= '0;
        cnt_q <= '0;
      end else begin
        rptr_q <= rptr_d;
        wptr_q <= wptr_d;
        cnt_q <= cnt_d;
      end
    end
    always_ff @(posedge clk) begin
      if (we[r]) mem_q[wptr_q] <= bus.wr_data;
    end
  end
`ifdef ROW_FEED_SKEW_EN
  logic [ROWS-1:0] any_v;
  assign bus.busy = |any_v;
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [r:0] v_q;
    logic [WORDLEN-1:0] d_q [r+1];
    assign any_v[r] = |v_q;
    assign bus.out_valid[r] = v_q[r];
    assign bus.out_data[r*WORDLEN +: WORDLEN] = v_q[r] ? d_q[r] : '0;
    always_ff @(posedge clk) begin
      if (rst || bus.flush) v_q <= '0;
      else v_q <= (r+1)'({v_q, pop});
    end
    always_ff @(posedge clk) begin
      d_q[0] <= head[r*WORDLEN +: WORDLEN];
      for (int k = 1; k <= r; k++) d_q[k] <= d_q[k-1];
    end
  end
`else
  logic v_q;
  logic [ROWS*WORDLEN-1:0] d_q;
  assign bus.busy = v_q;
  assign bus.out_valid = {ROWS{v_q}};
  assign bus.out_data = v_q ? d_q : '0;
  always_ff @(posedge clk) begin
    v_q <= !rst && !bus.flush && pop;
    d_q <= head;
  end
`endif
endmodule

// File: tb/tb_row_feed_buf.sv
// tb_row_feed_buf: queue-based reference model of row_feed_buf under directed and random traffic.
module tb_row_feed_buf;
  localparam int W = 8, D = 4, R = 4;
`ifdef ROW_FEED_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  row_feed_if #(.WORDLEN(W), .ROWS(R)) bus ();
  row_feed_if #(.WORDLEN(W), .ROWS(3)) bus3 ();
  row_feed_buf #(.WORDLEN(W), .DEPTH(D), .ROWS(R)) dut (.clk(clk), .rst(rst), .bus(bus));
  row_feed_buf #(.WORDLEN(W), .DEPTH(D), .ROWS(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  int checks = 0, errors = 0;
  logic [W-1:0] q [R][$];
  logic hv [R];
  logic [W-1:0] hd [R][R];
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  // Called at a negedge: check current state, apply inputs, advance one clock and the model.
  task automatic step(input logic r_i, input logic f_i, input logic wv, input logic [1:0] row,
                      input logic [W-1:0] data, input logic rd);
    logic [R-1:0] ev, ee, ef;
    logic [R*W-1:0] ed;
    logic eb, rd_ok, wr_ok;
    eb = 1'b0;
    for (int r = 0; r < R; r++) begin
      int idx;
      idx = SKEW ? r : 0;
      ev[r] = hv[idx];
      ed[r*W +: W] = hv[idx] ? hd[idx][r] : '0;
      ee[r] = q[r].size() == 0;
      ef[r] = q[r].size() == D;
      if (SKEW || r == 0) eb |= hv[r];
    end
    check("out_valid", 64'(bus.out_valid), 64'(ev));
    check("out_data", 64'(bus.out_data), 64'(ed));
    check("busy", 64'(bus.busy), 64'(eb));
    check("empty", 64'(bus.empty), 64'(ee));
    check("full", 64'(bus.full), 64'(ef));
    rst = r_i;
    bus.flush = f_i;
    bus.wr_valid = wv;
    bus.wr_row = row;
    bus.wr_data = data;
    bus.rd_en = rd;
    #1;
    rd_ok = ee == '0;
    wr_ok = q[row].size() < D;
    check("wr_ready", 64'(bus.wr_ready), 64'(wr_ok));
    check("rd_ready", 64'(bus.rd_ready), 64'(rd_ok));
    @(posedge clk);
    if (r_i || f_i) begin
      for (int r = 0; r < R; r++) begin
        q[r].delete();
        hv[r] = 1'b0;
      end
    end else begin
      for (int k = R - 1; k > 0; k--) begin
        hv[k] = hv[k-1];
        for (int r = 0; r < R; r++) hd[k][r] = hd[k-1][r];
      end
      hv[0] = rd && rd_ok;
      if (hv[0]) for (int r = 0; r < R; r++) hd[0][r] = q[r].pop_front();
      if (wv && wr_ok) q[row].push_back(data);
    end
    @(negedge clk);
  endtask
  initial begin
    for (int r = 0; r < R; r++) hv[r] = 1'b0;
    rst = 1'b1;
    bus.flush = 1'b0; bus.wr_valid = 1'b0; bus.wr_row = '0; bus.wr_data = '0; bus.rd_en = 1'b0;
    bus3.flush = 1'b0; bus3.wr_valid = 1'b1; bus3.wr_row = 2'd3; bus3.wr_data = 8'h55; bus3.rd_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // One word per row, single pop, watch the skewed drain.
    for (int r = 0; r < R; r++) step(0, 0, 1, 2'(r), 8'(8'h10 + r), 0);
    step(0, 0, 0, 0, 0, 1);
    repeat (6) step(0, 0, 0, 0, 0, 0);
    // Fill rows 0,1,3, overfill row 2, full-row write with pop, then drain across the wrap.
    for (int r = 0; r < R; r++)
      if (r != 2) for (int i = 0; i < D; i++) step(0, 0, 1, 2'(r), 8'($urandom), 0);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 2'd2, 8'(8'hA0 + i), 0);
    step(0, 0, 1, 2'd1, 8'hEE, 1);
    repeat (4) step(0, 0, 0, 0, 0, 1);
    repeat (6) step(0, 0, 0, 0, 0, 0);
    // Reset and then flush in the middle of a two-pop skew drain.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 2; i++)
        for (int r = 0; r < R; r++) step(0, 0, 1, 2'(r), 8'($urandom), 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(pass == 0, pass == 1, 1, 2'd0, 8'h77, 1);
      repeat (3) step(0, 0, 0, 0, 0, 0);
    end
    check("oor_wr_ready", 64'(bus3.wr_ready), 64'(0));
    check("oor_empty", 64'(bus3.empty), 64'(3'b111));
    repeat (3000)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 99) < 65,
           2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 99) < 40);
    repeat (R + 2) step(0, 0, 0, 0, 0, 0);
    bus3.wr_row = 2'd2;
    #1;
    check("row3_wr_ready", 64'(bus3.wr_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    check("row3_empty", 64'(bus3.empty), 64'(3'b011));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/row_feed_buf.md
ROW_FEED_BUF -- requirements
Module: row_feed_buf

Interface
REQ-001 SHALL have parameter WORDLEN, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, words per row FIFO (legal range >= 2, not required to be a power of two).
REQ-003 SHALL have parameter ROWS, default 16, number of row channels (legal range >= 2); RB = max(1, clog2(ROWS)).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  synchronous clear of all FIFOs and the skew pipeline.
REQ-007 wr_valid  input  1  write request.
REQ-008 wr_row  input  RB  target row of the write.
REQ-009 wr_data  input  WORDLEN  write word.
REQ-010 wr_ready  output  1  write accepted this cycle when high together with wr_valid.
REQ-011 rd_en  input  1  request to pop one word from every row simultaneously.
REQ-012 rd_ready  output  1  high when every row FIFO is non-empty.
REQ-013 out_data  output  ROWS*WORDLEN  row r word on bits [r*WORDLEN +: WORDLEN].
REQ-014 out_valid  output  ROWS  per-row output valid.
REQ-015 empty / full  output  ROWS each  per-row FIFO status.
REQ-016 busy  output  1  high while any skew-pipeline stage holds a valid word.

Function
REQ-017 Each row SHALL be a circular FIFO with read/write pointers of clog2(DEPTH) bits wrapping from DEPTH-1 to 0, and a count of clog2(DEPTH+1) bits.
REQ-018 wr_ready = (wr_row < ROWS) && !full[wr_row]; computed combinationally from registered count; out-of-range wr_row never writes.
REQ-019 Write fires when wr_valid && wr_ready: word stored at write pointer of wr_row, pointer and count advance.
REQ-020 Pop fires when rd_en && rd_ready: every row's head word is read, all read pointers advance, all counts decrement, in the same cycle.
REQ-021 rd_en while rd_ready low SHALL be ignored with no state change.
REQ-022 Simultaneous write and pop on one row SHALL both take effect; count unchanged for that row.
REQ-023 No bypass: write to a full row is refused even if a pop fires that cycle; a word written to an empty row is not poppable until the next cycle.
REQ-024 Popped words SHALL enter a skew pipeline; row r word appears on out_data with out_valid[r]=1 exactly 1+r cycles after the pop cycle.
REQ-025 Back-to-back pops SHALL stream at one word per row per cycle with no bubbles.
REQ-026 When out_valid[r]=0, row r slice of out_data SHALL be zero.
REQ-027 busy = OR of all skew-stage valid bits.
REQ-028 flush SHALL clear pointers, counts and all skew stages next edge; flush has priority over same-cycle write and pop (both dropped); wr_ready and rd_ready are not gated by flush.

Reset
REQ-029 On rst, all pointers, counts, skew stages cleared: out_data=0, out_valid=0, busy=0, empty=all ones, full=0, rd_ready=0.
REQ-030 rst SHALL override flush, write and pop; reset mid-stream discards all buffered and in-flight words.
REQ-031 FIFO storage arrays need not be cleared by reset.

Configuration
REQ-032 Macro ROW_FEED_SKEW_EN SHALL select skew.
REQ-033 With ROW_FEED_SKEW_EN defined: behaviour per REQ-024.
REQ-034 Without it: all rows appear together 1 cycle after the pop, out_valid all ones or all zero; busy equals out_valid[0]; no per-row delay registers synthesised.

Verification (ROWS=4, DEPTH=4, WORDLEN=8, skew enabled unless stated)
REQ-035 Write 0x10+r to each row r, pulse rd_en once -> out_valid[r] high only at cycle 1+r with slice 0x10+r; busy high cycles 1..4.
REQ-036 Write 5 words 0xA0..0xA4 to row 2 -> first four accepted, fifth sees wr_ready=0, full[2]=1; later pops return 0xA0..0xA3 in order across pointer wrap.
REQ-037 Rows 0,1,3 loaded, row 2 empty, rd_en held -> no pop, counts unchanged; write row 2 -> rd_ready rises next cycle.
REQ-038 Full row 1, same-cycle write and pop -> pop fires, write refused; wr_row=5 (ROWS=4 with RB=2 unreachable; use ROWS=3, wr_row=3) -> wr_ready=0.
REQ-039 Pop two cycles, assert rst mid-skew -> next cycle out_valid=0, out_data=0, empty=all ones; repeat with flush -> same result.
REQ-040 Macro undefined, scenario REQ-035 -> all four slices valid together at cycle 1.
